instr_prefetch_queue: RTL

Instruction fetch front-end sitting directly upstream of the pipeline's IF/ID state register. It drives a multi-cycle instruction memory through a request/response handshake, buffers returned instructions with their PC+4 in a small FIFO, and presents one instruction per cycle to the IF/ID register. It honours pipeline stalls through a take signal and discards wrong-path work on branch/jump redirects resolved in ID.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/instr_prefetch_queue.sv | 99 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch front-end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_e;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x WIDTH synchronous FIFO with clear; head shows the oldest entry.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue feeding IF/ID: one outstanding fetch, redirect flush.
// Define PREFETCH_BYPASS_EN to forward a response straight to out_* when the FIFO is empty.
module instr_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    input  logic                    take,
    output logic                    out_valid,
    output logic [31:0]             out_instr,
    output logic [31:0]             out_pc_plus4,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_e  state, state_nxt;
    logic [31:0]   fetch_pc, issued_pc, rsp_pc4;
    logic [CW-1:0] count;
    logic [63:0]   head;
    logic          fifo_ne, grant, rsp_live, byp, push, pop;
    logic          unused_redir_lsb;

    assign unused_redir_lsb = ^redirect_pc[1:0];

    assign fifo_ne  = (count != '0);
    assign rsp_pc4  = issued_pc + 32'(WORD_BYTES);
    assign rsp_live = (state == WAIT) && mem_rvalid && !redirect;

`ifdef PREFETCH_BYPASS_EN
    assign byp = rsp_live && !fifo_ne;
`else
    assign byp = 1'b0;
`endif

    // A bypassed response that is consumed immediately never occupies an entry.
    assign push = rsp_live && !(byp && take);
    assign pop  = take && fifo_ne && !redirect;

    assign mem_req  = !reset && (state == IDLE) && !redirect && (count != FULL);
    assign mem_addr = fetch_pc;
    assign grant    = mem_req && mem_gnt;

    assign out_valid    = fifo_ne || byp;
    assign out_instr    = fifo_ne ? head[63:32] : (byp ? mem_rdata : 32'h0);
    assign out_pc_plus4 = fifo_ne ? head[31:0]  : (byp ? rsp_pc4   : 32'h0);
    assign occupancy    = count;

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .push_data ({mem_rdata, rsp_pc4}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = WAIT;
            // A response landing in the redirect cycle is simply discarded.
            WAIT:    if (mem_rvalid) state_nxt = IDLE;
                     else if (redirect) state_nxt = DROP;
            DROP:    if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
        end else begin
            state <= state_nxt;
            if (redirect)
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (grant)
                fetch_pc <= fetch_pc + 32'(WORD_BYTES);
            if (grant)
                issued_pc <= fetch_pc;
        end
    end

endmodule
